// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg: shared seven-segment constants, digit encoder and converter states
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    B27S_IDLE   = 2'd0,
    B27S_SHIFT  = 2'd1,
    B27S_ENCODE = 2'd2
  } b27s_state_t;

  // Active-low pattern, bit 0 = segment a .. bit 6 = segment g
  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_7segs.sv
// ============================================================================
// bin_to_7segs: sequential double-dabble binary-to-BCD converter feeding eight
// active-low seven-segment patterns with leading-zero blanking and overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_7segs
  import seg7_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             ready,
  output logic             done,
  output logic [6:0]       segs_7seg [NUM_DIGITS]
);

  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  b27s_state_t      state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [31:0]      bcd_q,   bcd_d;
  logic [4:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             done_q,  done_d;
  logic [6:0]       segs_q [NUM_DIGITS];
  logic [6:0]       segs_d [NUM_DIGITS];

  logic             w_ovf;
  logic [31:0]      w_bcd_adj;
  logic [6:0]       w_segs_enc [NUM_DIGITS];

  // Only a 27-bit operand can exceed the eight-digit range
  generate
    if (WIDTH == 27) begin : g_ovf_w27
      assign w_ovf = (value > 27'd99_999_999);
    end else begin : g_ovf_none
      assign w_ovf = 1'b0;
    end
  endgenerate

  always_comb begin
    w_bcd_adj = bcd_q;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) begin
        w_bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Scan from the top digit; blanking stops at the first nonzero digit
  always_comb begin : enc
    logic lead;
    lead = 1'b1;
    for (int n = NUM_DIGITS - 1; n >= 0; n--) begin
      if (ovf_q) begin
        w_segs_enc[n] = SEG_DASH;
      end else if (lead && (n != 0) && (bcd_q[n*4 +: 4] == 4'd0)) begin
        w_segs_enc[n] = SEG_BLANK;
      end else begin
        w_segs_enc[n] = seg7_digit(bcd_q[n*4 +: 4]);
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    segs_d  = segs_q;
    case (state_q)
      B27S_IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          ovf_d   = w_ovf;
          cnt_d   = '0;
          state_d = B27S_SHIFT;
        end
      end
      B27S_SHIFT: begin
        bcd_d = (w_bcd_adj << 1) | {31'd0, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = B27S_ENCODE;
        end
      end
      B27S_ENCODE: begin
        segs_d  = w_segs_enc;
        done_d  = 1'b1;
        state_d = B27S_IDLE;
      end
      default: state_d = B27S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= B27S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int n = 0; n < NUM_DIGITS; n++) begin
        segs_q[n] <= SEG_BLANK;
      end
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      segs_q  <= segs_d;
    end
  end

  assign ready     = (state_q == B27S_IDLE);
  assign done      = done_q;
  assign segs_7seg = segs_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_7segs.sv
// ============================================================================
// tb_bin_to_7segs: directed vectors with a queued scoreboard checked on done
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_7segs;

  localparam int WIDTH = 27;
  localparam int LAT   = WIDTH + 1;
  localparam logic [6:0] BL = 7'h7F;

  typedef struct packed {
    logic [55:0] segs;
    int          due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             ready;
  logic             done;
  logic [6:0]       segs_7seg [8];

  exp_t q [$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   a_cyc;

  bin_to_7segs #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .ready     (ready),
    .done      (done),
    .segs_7seg (segs_7seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [55:0] pack_segs();
    logic [55:0] p;
    for (int i = 0; i < 8; i++) p[i*7 +: 7] = segs_7seg[i];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = q.pop_front();
        check("segs", pack_segs(), mon_e.segs);
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called on a negedge; start is sampled on the following posedge
  task automatic do_start(input logic [WIDTH-1:0] v, input logic [55:0] s);
    exp_t e;
    check("ready_before_start", ready, 1);
    e.segs = s;
    e.due  = cyc + 1 + LAT;
    q.push_back(e);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = '0;
  endtask

  task automatic pulse_ignored(input logic [WIDTH-1:0] v);
    check("ready_low_busy", ready, 0);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_segs", pack_segs(), {8{BL}});
    repeat (50) @(negedge clk);
    check("idle_ready", ready, 1);

    do_start(0, {{7{BL}}, 7'h40});
    wait_drain();

    do_start(12_345_678, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    wait_drain();
    do_start(1005, {{4{BL}}, 7'h79, 7'h40, 7'h40, 7'h12});
    wait_drain();

    do_start(99_999_999, {8{7'h10}});
    wait_drain();
    do_start(100_000_000, {8{7'h3F}});
    wait_drain();

    a_cyc = cyc + 1;
    do_start(42, {{6{BL}}, 7'h19, 7'h24});
    while (cyc < a_cyc + 4) @(negedge clk);
    pulse_ignored(7);
    while (cyc < a_cyc + 26) @(negedge clk);
    pulse_ignored(7);
    pulse_ignored(7);
    check("done_cycle_ready", ready, 1);
    do_start(7, {{7{BL}}, 7'h78});
    wait_drain();

    a_cyc = cyc + 1;
    do_start(555, {{5{BL}}, 7'h12, 7'h12, 7'h12});
    while (cyc < a_cyc + 9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midreset_ready", ready, 1);
    check("midreset_done", done, 0);
    check("midreset_segs", pack_segs(), {8{BL}});
    repeat (40) @(negedge clk);
    do_start(9, {{7{BL}}, 7'h10});
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin_to_7segs.md
# bin_to_7segs

Converts an unsigned binary value into eight active-low seven-segment cathode patterns, one per digit. It sits directly upstream of `nexys_7segs` and drives that block's `inputs_7seg` array. Conversion is a sequential double-dabble (shift-and-add-3) followed by a one-cycle encode with leading-zero blanking and overflow indication. Upstream logic uses a start/ready/done handshake.

## Interface
- `WIDTH`, default 27: width of `value`. Legal range is 4..27.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a conversion. Accepted only in a cycle where `ready`=1.
- `value`  input  WIDTH  unsigned binary operand, sampled on the accepting edge.
- `ready`  output  1  block is idle and will accept `start`.
- `done`  output  1  one-cycle pulse: `segs_7seg` has just been updated.
- `segs_7seg[8]`  output  7 each  active-low cathode patterns.
  - Bit 0 = segment a through bit 6 = segment g.
  - Index 0 is the least-significant (rightmost) digit.

## Operation
- **States:** IDLE, SHIFT, ENCODE.
- **IDLE:** `ready`=1.
  - On `start`=1, capture `value` into the shift register and clear the 32-bit BCD register.
  - Set `ovf` = (`value` > 99_999_999). This can only be true when WIDTH=27.
  - Clear the bit counter and go to SHIFT.
- **SHIFT:** runs for exactly WIDTH cycles. Each cycle:
  - add 3 to every BCD nibble that is ≥5;
  - shift {bcd, bin} left by one.
  - When the counter reaches WIDTH-1, go to ENCODE.
- **ENCODE:** one cycle.
  - Register all eight `segs_7seg` entries and pulse `done`.
  - `ready` returns to 1 on the same edge; go to IDLE.
- **`start` handling:**
  - `start` is ignored while in SHIFT or ENCODE.
  - `value` is don't-care outside the accepting cycle.
- **Digit patterns** (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank=7F, dash=3F.
- **Leading-zero blanking:**
  - Every digit above the most-significant nonzero digit is blank.
  - Digit 0 is always shown, so a value of 0 displays a single "0".
  - Interior zeros are shown.
- **Overflow:** when `ovf`=1, all eight digits show dash.
- **Holding:** `segs_7seg` holds its last value between conversions. It changes only on ENCODE or on reset.

## Timing
- **Reset values:**
  - `ready`=1, `done`=0;
  - all `segs_7seg`=7F (blank);
  - state IDLE, internal registers cleared.
- **Latency:** call the accepting edge cycle 0.
  - SHIFT occupies cycles 1..WIDTH.
  - ENCODE edge is cycle WIDTH+1.
  - `done`=1 and new `segs_7seg` are visible during cycle WIDTH+1 to WIDTH+2; with WIDTH=27 that is 28 cycles after acceptance.
- **`ready`:** low from the cycle after acceptance through the ENCODE cycle, i.e. WIDTH+1 cycles. It is high again in the `done` cycle.
- **Back-to-back:** `start` asserted in the `done` cycle is accepted. Maximum throughput is one conversion per WIDTH+1 cycles.
- **Reset mid-operation:** `rst` in any state takes priority over `start`.
  - Next cycle: IDLE, `ready`=1, no `done` pulse, `segs_7seg` blank.
- **Width rules:**
  - BCD register is 32 bits (8 nibbles). Add-3 is applied per nibble with 4-bit wrap; no carry between nibbles.
  - Bit counter is 5 bits.
  - Overflow compare is done at full WIDTH against 27'd99_999_999, and only when WIDTH=27.

## Structure
- **Shared package `seg7_pkg`:**
  - `NUM_DIGITS`=8;
  - localparams `SEG_BLANK`=7'h7F and `SEG_DASH`=7'h3F;
  - function `seg7_digit(logic [3:0])` returning the active-low pattern, with non-decimal input returning `SEG_BLANK`;
  - state enum typedef `b27s_state_t`.
- **Sub-modules:** none required. Double-dabble and encode live in this module. `nexys_7segs` consumes `segs_7seg` unchanged.

## Test plan
1. Hold `rst`=1 for 3 cycles, then release → `ready`=1, `done`=0, all `segs_7seg`=7F, and no `done` for 50 idle cycles.
2. `start` with `value`=0 → `done` exactly 28 cycles after acceptance; `segs[0]`=40, `segs[7:1]`=7F.
3. `value`=12_345_678 → `segs[7..0]` = 79,24,30,19,12,02,78,00. Then `value`=1005 → `segs[3..0]` = 79,40,40,12 and `segs[7:4]`=7F.
4. `value`=99_999_999 → all eight digits = 10. `value`=100_000_000 → all eight digits = 3F (dash).
5. Start 42, then pulse `start` with 7 at cycles 5 and 27 → second request ignored, result shows "42" (`segs[1]`=19, `segs[0]`=24). Then start with 7 in the `done` cycle → accepted, second `done` 28 cycles later showing 78.
6. Start 555; assert `rst` at cycle 10 → no `done`, `ready`=1 next cycle, `segs_7seg` all 7F. A subsequent start with 9 completes normally with `segs[0]`=10.
